// File: rtl/pc_predictor_pkg.sv
// rtl/pc_predictor_pkg.sv - shared constants and helpers for the next-PC predictor
package pc_predictor_pkg;

  localparam int DATA_WIDTH = 32;
  localparam logic [DATA_WIDTH-1:0] ZERO_DATA = '0;

  localparam int OP_RANGE = 7;
  localparam logic [OP_RANGE-1:0] BRANCH_OP = 7'b1100011;
  localparam logic [OP_RANGE-1:0] JAL_OP    = 7'b1101111;
  localparam logic [OP_RANGE-1:0] JALR_OP   = 7'b1100111;

  localparam logic [4:0] LINK_REG_1 = 5'd1;
  localparam logic [4:0] LINK_REG_5 = 5'd5;

  // Weakly not-taken: one below the taken threshold.
  function automatic int cnt_init(input int cnt_w);
    return (1 << (cnt_w - 1)) - 1;
  endfunction

  function automatic logic is_link(input logic [4:0] r);
    return (r == LINK_REG_1) || (r == LINK_REG_5);
  endfunction

endpackage

// File: rtl/pc_predictor_ras.sv
// rtl/pc_predictor_ras.sv - circular return-address stack with saturating count
module pc_predictor_ras #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  input  logic              clear,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] push_data,
  output logic [DATA_W-1:0] top,
  output logic              empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  ptr;
  logic [PTR_W-1:0]  ptr_inc;
  logic [CNT_W-1:0]  count;
  logic              do_pop;

  // ptr addresses the current top entry; DEPTH is a power of two so the
  // increment wraps naturally onto the oldest slot once the stack is full.
  assign ptr_inc = ptr + 1'b1;
  assign do_pop  = pop && (count != '0);
  assign top     = mem[ptr];
  assign empty   = (count == '0);

  // Stack update: clear beats everything, pop+push replaces the top in place.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr   <= '0;
      count <= '0;
    end else if (ena) begin
      if (clear) begin
        ptr   <= '0;
        count <= '0;
      end else if (do_pop && push) begin
        mem[ptr] <= push_data;
      end else if (do_pop) begin
        ptr   <= ptr - 1'b1;
        count <= count - 1'b1;
      end else if (push) begin
        ptr          <= ptr_inc;
        mem[ptr_inc] <= push_data;
        if (count != CNT_W'(DEPTH)) count <= count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/pc_predictor.sv
// rtl/pc_predictor.sv - next fetch PC with bimodal/gshare counters, JAL and RAS returns
module pc_predictor
  import pc_predictor_pkg::*;
#(
  parameter int DATA_W    = DATA_WIDTH,
  parameter int IDX_W     = 7,
  parameter int CNT_W     = 2,
  parameter int HIST_W    = 0,
  parameter int RAS_DEPTH = 4,
  localparam int HW       = (HIST_W > 0) ? HIST_W : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  input  logic              in_fetcher_ena,
  input  logic [DATA_W-1:0] in_last_pc,
  input  logic [31:0]       in_last_inst,
  output logic [DATA_W-1:0] out_next_pc,
  output logic              out_next_taken,
  output logic [HW-1:0]     out_next_history,
  output logic              out_rollback,
  output logic [DATA_W-1:0] out_rollback_pc,
  input  logic              in_forwarding_valid,
  input  logic              in_forwarding_is_cond,
  input  logic              in_forwarding_branch_taken,
  input  logic [DATA_W-1:0] in_forwarding_branch_pc,
  input  logic [HW-1:0]     in_forwarding_history,
  input  logic              in_misbranch,
  input  logic [DATA_W-1:0] in_forwarding_correct_address
);

  localparam int TBL = 1 << IDX_W;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(cnt_init(CNT_W));
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic [OP_RANGE-1:0] opcode;
  logic [4:0]          rd;
  logic [4:0]          rs1;
  logic                is_br, is_jal, is_jalr, is_ret;
  logic signed [12:0]  b_imm;
  logic signed [20:0]  j_imm;
  logic [DATA_W-1:0]   b_off, j_off, pc_plus4, pred_target;

  logic [HW-1:0]       ghr;
  logic [IDX_W-1:0]    ghr_idx, upd_hist_idx;
  logic [IDX_W-1:0]    pred_idx, upd_idx;
  logic [CNT_W-1:0]    cnt_table [TBL];
  logic [CNT_W-1:0]    pred_cnt, upd_cnt;
  logic                br_taken;

  logic                mis_v, fetch_v;
  logic                ras_push, ras_pop, ras_empty;
  logic [DATA_W-1:0]   ras_top;
  logic                unused_bits;

  assign opcode  = in_last_inst[OP_RANGE-1:0];
  assign rd      = in_last_inst[11:7];
  assign rs1     = in_last_inst[19:15];
  assign is_br   = (opcode == BRANCH_OP);
  assign is_jal  = (opcode == JAL_OP);
  assign is_jalr = (opcode == JALR_OP);

  assign b_imm    = {in_last_inst[31], in_last_inst[7], in_last_inst[30:25], in_last_inst[11:8], 1'b0};
  assign j_imm    = {in_last_inst[31], in_last_inst[19:12], in_last_inst[20], in_last_inst[30:21], 1'b0};
  assign b_off    = DATA_W'(b_imm);
  assign j_off    = DATA_W'(j_imm);
  assign pc_plus4 = in_last_pc + DATA_W'(4);

  // History only folds into the index in gshare mode; bimodal keeps GHR at zero.
  generate
    if (HIST_W == 0) begin : g_bimodal
      assign ghr          = '0;
      assign ghr_idx      = '0;
      assign upd_hist_idx = '0;
    end else begin : g_gshare
      logic [HW-1:0] ghr_q, fetch_shift, mis_shift;
      if (HIST_W == 1) begin : g_h1
        assign fetch_shift = br_taken;
        assign mis_shift   = in_forwarding_branch_taken;
      end else begin : g_hn
        assign fetch_shift = {ghr_q[HW-2:0], br_taken};
        assign mis_shift   = {in_forwarding_history[HW-2:0], in_forwarding_branch_taken};
      end
      // Speculative history: shift predicted bits, repair from the snapshot on misbranch.
      always_ff @(posedge clk) begin
        if (rst) begin
          ghr_q <= '0;
        end else if (ena) begin
          if (mis_v) begin
            ghr_q <= in_forwarding_is_cond ? mis_shift : in_forwarding_history;
          end else if (in_fetcher_ena && is_br) begin
            ghr_q <= fetch_shift;
          end
        end
      end
      assign ghr          = ghr_q;
      assign ghr_idx      = IDX_W'(ghr_q);
      assign upd_hist_idx = IDX_W'(in_forwarding_history);
    end
  endgenerate

  assign pred_idx = in_last_pc[IDX_W+1:2] ^ ghr_idx;
  assign upd_idx  = in_forwarding_branch_pc[IDX_W+1:2] ^ upd_hist_idx;
  assign pred_cnt = cnt_table[pred_idx];
  assign upd_cnt  = cnt_table[upd_idx];
  assign br_taken = pred_cnt[CNT_W-1];

  assign is_ret = is_jalr && is_link(rs1) && (rd == 5'd0) && !ras_empty;

  assign out_next_taken   = is_br ? br_taken : (is_jal ? 1'b1 : is_ret);
  assign out_next_history = ghr;
  assign out_rollback     = in_misbranch;
  assign out_rollback_pc  = in_forwarding_correct_address;

  // Target of the instruction just fetched, assuming the prediction holds.
  always_comb begin
    pred_target = pc_plus4;
    if (is_br && br_taken) pred_target = in_last_pc + b_off;
    else if (is_jal)       pred_target = in_last_pc + j_off;
    else if (is_ret)       pred_target = ras_top;
  end

  assign mis_v   = in_misbranch && in_forwarding_valid;
  assign fetch_v = in_fetcher_ena && !mis_v;

  // A coroutine JALR (both link regs, different) pops then pushes in one cycle.
  assign ras_push = fetch_v && (is_jal || is_jalr) && is_link(rd);
  assign ras_pop  = fetch_v && (is_ret || (is_jalr && is_link(rd) && is_link(rs1) && (rd != rs1)));

  pc_predictor_ras #(
    .DATA_W (DATA_W),
    .DEPTH  (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .rst       (rst),
    .ena       (ena),
    .clear     (mis_v),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_data (pc_plus4),
    .top       (ras_top),
    .empty     (ras_empty)
  );

  // Next fetch PC: rollback first, then the predicted target, else hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_next_pc <= DATA_W'(ZERO_DATA);
    end else if (ena) begin
      if (mis_v)               out_next_pc <= in_forwarding_correct_address;
      else if (in_fetcher_ena) out_next_pc <= pred_target;
    end
  end

  // Counter training from resolved branches; runs even while the fetch side is stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < TBL; i++) cnt_table[i] <= CNT_INIT;
    end else if (in_forwarding_valid && in_forwarding_is_cond) begin
      if (in_forwarding_branch_taken) begin
        if (upd_cnt != CNT_MAX) cnt_table[upd_idx] <= upd_cnt + 1'b1;
      end else begin
        if (upd_cnt != '0) cnt_table[upd_idx] <= upd_cnt - 1'b1;
      end
    end
  end

  assign unused_bits = ^{in_forwarding_branch_pc, in_forwarding_history};

endmodule
